// File: rtl/pe_mac_stream.sv
// Systolic MAC processing element: forwards operands east/south and accumulates framed dot products.
// Optional macro PE_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module pe_mac_stream #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 0
) (
  input  logic              i_clk,
  input  logic              i_arst,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_valid,
  input  logic              i_last,
  input  logic              i_clear,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic              o_valid,
  output logic              o_last,
  output logic [ACC_W-1:0]  o_c,
  output logic              o_c_valid,
  output logic              o_c_ovf
);

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t                     state, state_nxt;
  logic [ACC_W-1:0]           acc, acc_nxt, prod, sum, add_res;
  logic                       ovf, ovf_nxt, add_ovf, done;
  logic signed [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0]        prod_u;
  logic [ACC_W:0]             sum_ext;

  generate
    if (ACC_W < 2*DATA_W) begin : g_width_check
      $error("pe_mac_stream: ACC_W must be at least 2*DATA_W");
    end
  endgenerate

  assign prod_s  = $signed({{DATA_W{i_a[DATA_W-1]}}, i_a}) * $signed({{DATA_W{i_b[DATA_W-1]}}, i_b});
  assign prod_u  = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};
  assign sum_ext = {1'b0, acc} + {1'b0, prod};
  assign sum     = sum_ext[ACC_W-1:0];

  always_comb begin
    if (SIGNED != 0) begin
      prod    = ACC_W'(prod_s);
      // Signed overflow: addends agree in sign but the result does not.
      add_ovf = (acc[ACC_W-1] == prod[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    end else begin
      prod    = ACC_W'(prod_u);
      add_ovf = sum_ext[ACC_W];
    end
  end

`ifdef PE_SATURATE_EN
  logic [ACC_W-1:0] sat_val;

  always_comb begin
    if (SIGNED != 0)
      sat_val = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sat_val = '1;
    add_res = add_ovf ? sat_val : sum;
  end
`else
  assign add_res = sum;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_arst) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    if (i_valid)      state_nxt = i_last ? IDLE : ACC;
    else if (i_clear) state_nxt = IDLE;
  end

  // A clear makes this beat behave as if the FSM were idle.
  always_comb begin
    acc_nxt = acc;
    ovf_nxt = ovf;
    done    = 1'b0;
    if (i_valid) begin
      if (state == IDLE || i_clear) begin
        acc_nxt = prod;
        ovf_nxt = 1'b0;
      end else begin
        acc_nxt = add_res;
        ovf_nxt = ovf | add_ovf;
      end
      done = i_last;
    end else if (i_clear) begin
      acc_nxt = '0;
      ovf_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      acc       <= '0;
      ovf       <= 1'b0;
      o_a       <= '0;
      o_b       <= '0;
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
      o_c       <= '0;
      o_c_valid <= 1'b0;
      o_c_ovf   <= 1'b0;
    end else begin
      acc       <= acc_nxt;
      ovf       <= ovf_nxt;
      o_valid   <= i_valid;
      o_last    <= i_valid & i_last;
      o_c_valid <= done;
      if (i_valid) begin
        o_a <= i_a;
        o_b <= i_b;
      end
      if (done) begin
        o_c     <= acc_nxt;
        o_c_ovf <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_stream.sv
// Self-checking bench for pe_mac_stream: three configurations (32-bit unsigned, 16-bit unsigned,
// 32-bit signed) share one stimulus stream and are compared every cycle against a behavioural model.
module tb_pe_mac_stream;

`ifdef PE_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       v;
    logic       l;
    logic       c;
    logic       r;
  } beat_t;

  logic       i_clk = 1'b0;
  logic       i_arst = 1'b1;
  logic [7:0] i_a = '0, i_b = '0;
  logic       i_valid = 1'b0, i_last = 1'b0, i_clear = 1'b0;

  logic [7:0]  o_a0, o_b0, o_a1, o_b1, o_a2, o_b2;
  logic        o_valid0, o_last0, o_cv0, o_ovf0;
  logic        o_valid1, o_last1, o_cv1, o_ovf1;
  logic        o_valid2, o_last2, o_cv2, o_ovf2;
  logic [31:0] o_c0, o_c2;
  logic [15:0] o_c1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  pe_mac_stream #(.DATA_W(8), .ACC_W(32), .SIGNED(0)) u0 (
    .i_clk(i_clk), .i_arst(i_arst), .i_a(i_a), .i_b(i_b), .i_valid(i_valid), .i_last(i_last),
    .i_clear(i_clear), .o_a(o_a0), .o_b(o_b0), .o_valid(o_valid0), .o_last(o_last0),
    .o_c(o_c0), .o_c_valid(o_cv0), .o_c_ovf(o_ovf0));

  pe_mac_stream #(.DATA_W(8), .ACC_W(16), .SIGNED(0)) u1 (
    .i_clk(i_clk), .i_arst(i_arst), .i_a(i_a), .i_b(i_b), .i_valid(i_valid), .i_last(i_last),
    .i_clear(i_clear), .o_a(o_a1), .o_b(o_b1), .o_valid(o_valid1), .o_last(o_last1),
    .o_c(o_c1), .o_c_valid(o_cv1), .o_c_ovf(o_ovf1));

  pe_mac_stream #(.DATA_W(8), .ACC_W(32), .SIGNED(1)) u2 (
    .i_clk(i_clk), .i_arst(i_arst), .i_a(i_a), .i_b(i_b), .i_valid(i_valid), .i_last(i_last),
    .i_clear(i_clear), .o_a(o_a2), .o_b(o_b2), .o_valid(o_valid2), .o_last(o_last2),
    .o_c(o_c2), .o_c_valid(o_cv2), .o_c_ovf(o_ovf2));

  // Layout: [51:44] o_a, [43:36] o_b, [35] o_valid, [34] o_last, [33:2] o_c, [1] o_c_valid, [0] o_c_ovf
  logic [51:0] obs [3];
  assign obs[0] = {o_a0, o_b0, o_valid0, o_last0, o_c0, o_cv0, o_ovf0};
  assign obs[1] = {o_a1, o_b1, o_valid1, o_last1, 16'd0, o_c1, o_cv1, o_ovf1};
  assign obs[2] = {o_a2, o_b2, o_valid2, o_last2, o_c2, o_cv2, o_ovf2};

  // Reference model: frame sum held as a plain integer, range-checked against the result width.
  bit          m_busy [3];
  longint      m_sum  [3];
  bit          m_ovf  [3];
  logic [7:0]  e_a [3], e_b [3];
  logic        e_v [3], e_l [3], e_cv [3], e_ovf [3];
  logic [31:0] e_c [3];

  function automatic int acc_w(int k);
    return (k == 1) ? 16 : 32;
  endfunction

  function automatic logic [51:0] exp_vec(int k);
    return {e_a[k], e_b[k], e_v[k], e_l[k], e_c[k], e_cv[k], e_ovf[k]};
  endfunction

  task automatic model_step(input beat_t s);
    for (int k = 0; k < 3; k++) begin
      longint p, t, hi, lo, mask;
      int w;
      w    = acc_w(k);
      mask = (longint'(1) << w) - 1;
      if (k == 2) begin
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        p  = longint'($signed(s.a)) * longint'($signed(s.b));
      end else begin
        hi = mask;
        lo = 0;
        p  = longint'(s.a) * longint'(s.b);
      end
      if (s.r) begin
        m_busy[k] = 1'b0; m_sum[k] = 0; m_ovf[k] = 1'b0;
        e_a[k] = '0; e_b[k] = '0; e_v[k] = 1'b0; e_l[k] = 1'b0;
        e_c[k] = '0; e_cv[k] = 1'b0; e_ovf[k] = 1'b0;
      end else begin
        e_v[k]  = s.v;
        e_l[k]  = s.v & s.l;
        e_cv[k] = 1'b0;
        if (s.v) begin
          e_a[k] = s.a;
          e_b[k] = s.b;
          if (!m_busy[k] || s.c) begin
            m_sum[k] = p;
            m_ovf[k] = 1'b0;
          end else begin
            t = m_sum[k] + p;
            if (t > hi || t < lo) begin
              m_ovf[k] = 1'b1;
              if (SAT)        t = (t > hi) ? hi : lo;
              else if (t > hi) t = t - (longint'(1) << w);
              else            t = t + (longint'(1) << w);
            end
            m_sum[k] = t;
          end
          if (s.l) begin
            t        = m_sum[k] & mask;
            e_c[k]   = t[31:0];
            e_ovf[k] = m_ovf[k];
            e_cv[k]  = 1'b1;
            m_busy[k] = 1'b0;
          end else begin
            m_busy[k] = 1'b1;
          end
        end else if (s.c) begin
          m_busy[k] = 1'b0; m_sum[k] = 0; m_ovf[k] = 1'b0;
        end
      end
    end
  endtask

  // Applies one beat for one clock edge, advances the model, and returns 1 ns after the edge.
  task automatic drive(input beat_t s);
    i_a = s.a; i_b = s.b; i_valid = s.v; i_last = s.l; i_clear = s.c; i_arst = s.r;
    @(posedge i_clk);
    model_step(s);
    #1;
  endtask

  task automatic test_reset();
    beat_t s;
    s = '{a: 8'h5A, b: 8'hA5, v: 1'b1, l: 1'b1, c: 1'b1, r: 1'b1};
    for (int i = 0; i < 2; i++) begin
      drive(s);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== 52'd0) begin
          n_bad++;
          $display("FAIL reset[%0d] dut%0d: got %h expected 0", i, k, obs[k]);
        end
      end
    end
  endtask

  task automatic test_basic();
    beat_t seq [4];
    seq = '{'{8'd2, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0}, '{8'd4, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0},
            '{8'd6, 8'd7, 1'b1, 1'b1, 1'b0, 1'b0}, '{8'd9, 8'd9, 1'b0, 1'b0, 1'b0, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      drive(seq[i]);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== exp_vec(k)) begin
          n_bad++;
          $display("FAIL basic[%0d] dut%0d: got %h expected %h", i, k, obs[k], exp_vec(k));
        end
      end
      n_cmp++;
      if (obs[0][1] !== (i == 2)) begin
        n_bad++;
        $display("FAIL basic_pulse[%0d]: got o_c_valid=%b", i, obs[0][1]);
      end
    end
    n_cmp++;
    if (obs[0][33:0] !== {32'd68, 1'b0, 1'b0} || obs[0][51:36] !== {8'd6, 8'd7}) begin
      n_bad++;
      $display("FAIL basic_result: got %h expected o_c=68 ovf=0 o_a=6 o_b=7", obs[0]);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] want;
    beat_t seq [2];
    want = SAT ? 32'd65535 : 32'd64514;
    seq = '{'{8'd255, 8'd255, 1'b1, 1'b0, 1'b0, 1'b0}, '{8'd255, 8'd255, 1'b1, 1'b1, 1'b0, 1'b0}};
    for (int i = 0; i < 2; i++) begin
      drive(seq[i]);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== exp_vec(k)) begin
          n_bad++;
          $display("FAIL overflow[%0d] dut%0d: got %h expected %h", i, k, obs[k], exp_vec(k));
        end
      end
    end
    n_cmp++;
    if (obs[1][33:0] !== {want, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL overflow_acc16: got o_c=%0d cv=%b ovf=%b expected o_c=%0d cv=1 ovf=1",
               obs[1][33:2], obs[1][1], obs[1][0], want);
    end
  endtask

  task automatic test_signed();
    beat_t seq [3];
    seq = '{'{8'hFD, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0}, '{8'd5, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0},
            '{8'd7, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      drive(seq[i]);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== exp_vec(k)) begin
          n_bad++;
          $display("FAIL signed[%0d] dut%0d: got %h expected %h", i, k, obs[k], exp_vec(k));
        end
      end
    end
    n_cmp++;
    if (obs[2][33:0] !== {32'hFFFF_FFF1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL signed_result: got o_c=%h cv=%b ovf=%b expected fffffff1 1 0",
               obs[2][33:2], obs[2][1], obs[2][0]);
    end
  endtask

  task automatic test_clear();
    int pulses;
    beat_t seq [5];
    pulses = 0;
    seq = '{'{8'd1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0}, '{8'd2, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0},
            '{8'd3, 8'd3, 1'b1, 1'b1, 1'b1, 1'b0}, '{8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{8'd4, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      drive(seq[i]);
      pulses += int'(obs[0][1]);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== exp_vec(k)) begin
          n_bad++;
          $display("FAIL clear[%0d] dut%0d: got %h expected %h", i, k, obs[k], exp_vec(k));
        end
      end
      if (i == 2) begin
        n_cmp++;
        if (obs[0][33:2] !== 32'd9) begin
          n_bad++;
          $display("FAIL clear_result: got o_c=%0d expected 9", obs[0][33:2]);
        end
      end
    end
    // A clear with no beat drops the partial sum started above without touching o_c.
    seq[0] = '{8'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    seq[1] = '{8'd5, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      drive(seq[i]);
      pulses += int'(obs[0][1]);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== exp_vec(k)) begin
          n_bad++;
          $display("FAIL clear_idle[%0d] dut%0d: got %h expected %h", i, k, obs[k], exp_vec(k));
        end
      end
    end
    n_cmp++;
    if (pulses != 2 || obs[0][33:2] !== 32'd25) begin
      n_bad++;
      $display("FAIL clear_pulses: got %0d pulses o_c=%0d expected 2 pulses o_c=25", pulses, obs[0][33:2]);
    end
  endtask

  task automatic test_back_to_back();
    beat_t seq [8];
    seq = '{'{8'd1, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0}, '{8'd3, 8'd4, 1'b1, 1'b1, 1'b0, 1'b0},
            '{8'd1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0}, '{8'd7, 8'd7, 1'b0, 1'b1, 1'b0, 1'b0},
            '{8'd2, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0}, '{8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0}, '{8'd3, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0}};
    for (int i = 0; i < 8; i++) begin
      drive(seq[i]);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== exp_vec(k)) begin
          n_bad++;
          $display("FAIL b2b[%0d] dut%0d: got %h expected %h", i, k, obs[k], exp_vec(k));
        end
      end
      if (i == 0 || i == 1 || i == 7) begin
        logic [31:0] want;
        want = (i == 0) ? 32'd2 : (i == 1) ? 32'd12 : 32'd14;
        n_cmp++;
        if (obs[0][33:1] !== {want, 1'b1}) begin
          n_bad++;
          $display("FAIL b2b_result[%0d]: got o_c=%0d cv=%b expected o_c=%0d cv=1",
                   i, obs[0][33:2], obs[0][1], want);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    beat_t seq [3];
    seq = '{'{8'd9, 8'd9, 1'b1, 1'b0, 1'b0, 1'b0}, '{8'd8, 8'd8, 1'b1, 1'b1, 1'b0, 1'b1},
            '{8'd1, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      drive(seq[i]);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== exp_vec(k)) begin
          n_bad++;
          $display("FAIL reset_mid[%0d] dut%0d: got %h expected %h", i, k, obs[k], exp_vec(k));
        end
      end
      if (i == 1) begin
        n_cmp++;
        if (obs[0] !== 52'd0) begin
          n_bad++;
          $display("FAIL reset_mid_zero: got %h expected 0", obs[0]);
        end
      end
    end
    n_cmp++;
    if (obs[0][33:0] !== {32'd1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid_fresh: got o_c=%0d cv=%b ovf=%b expected 1 1 0",
               obs[0][33:2], obs[0][1], obs[0][0]);
    end
  endtask

  task automatic test_random();
    beat_t s;
    for (int i = 0; i < 3000; i++) begin
      s.a = 8'($urandom);
      s.b = 8'($urandom);
      s.v = ($urandom_range(0, 99) < 70);
      s.l = ($urandom_range(0, 99) < 25);
      s.c = ($urandom_range(0, 99) < 5);
      s.r = ($urandom_range(0, 199) == 0);
      drive(s);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== exp_vec(k)) begin
          n_bad++;
          $display("FAIL random[%0d] dut%0d: got %h expected %h", i, k, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_signed();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
